// File: rtl/bram_array_singleport_pkg.sv
// Shared definitions for the banked single-port BRAM array: controller
// states, the capacity of one physical BRAM bank and a parameter sanity check.
package bram_array_singleport_pkg;

    // Capacity of one physical block RAM, in bits.
    localparam int BRAM_BITS = 16384;

    // CLEAR zero-fills every bank after reset; IDLE serves requests.
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_e;

    // Data widths that map cleanly onto one 16 Kbit bank.
    function automatic bit width_legal(input int w);
        return (w == 1) || (w == 2) || (w == 4) || (w == 8) || (w == 16) || (w == 32);
    endfunction

endpackage

// File: rtl/bram_array_singleport_bank.sv
// One 16 Kbit single-port block RAM in no-change mode: a write leaves the read
// register untouched, and a read registers the addressed word.
module bram_bank
    import bram_array_singleport_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = BRAM_BITS / WIDTH
) (
    input  logic                     clk,
    input  logic                     ce,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] dout_q;

    // Single port: write the word, or register the read word, when enabled.
    always_ff @(posedge clk) begin
        if (ce) begin
            if (we) begin
                mem[addr] <= din;
            end else begin
                dout_q <= mem[addr];
            end
        end
    end

    assign dout = dout_q;

endmodule

// File: rtl/bram_array_singleport.sv
// Banked single-port memory built from BLOCKS 16 Kbit BRAMs. After reset it can
// zero every bank in parallel, then accepts one read or write per cycle.
// Reads return after 1 (+1 with OUTREG) cycles; out-of-range reads flag rsp_err.
module bram_array_singleport
    import bram_array_singleport_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int BLOCKS = 4,
    parameter int OUTREG = 0,
    parameter int CLEAR  = 1,
    parameter int WPB    = BRAM_BITS / WIDTH,
    parameter int AW     = $clog2(BLOCKS * WPB)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [AW-1:0]    req_addr,
    input  logic [WIDTH-1:0] req_data,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err,
    output logic             busy
);

    localparam int          LAW         = $clog2(WPB);
    localparam logic [31:0] DEPTH_U     = 32'(BLOCKS * WPB);
    localparam state_e      RESET_STATE = (CLEAR != 0) ? ST_CLEAR : ST_IDLE;

    if (!width_legal(WIDTH) || BLOCKS < 1 || BLOCKS > 8) begin : g_param_check
        $error("bram_array_singleport: illegal WIDTH or BLOCKS");
    end

    state_e           state_q, state_d;
    logic [LAW-1:0]   clr_cnt_q, clr_cnt_d;
    logic             clearing, accept, addr_oor, bank_req;
    logic [3:0]       req_sel;
    logic [LAW-1:0]   req_local;
    logic [BLOCKS-1:0] bank_ce;
    logic             bank_we;
    logic [LAW-1:0]   bank_addr;
    logic [WIDTH-1:0] bank_din;
    logic [WIDTH-1:0] bank_dout [BLOCKS];
    logic             rd_vld1_q, rd_vld1_d, rd_err1_q, rd_err1_d;
    logic [3:0]       rd_sel1_q, rd_sel1_d;
    logic [WIDTH-1:0] rd_mux;
    logic [WIDTH-1:0] out_data_q, out_data_d;

    assign clearing  = (state_q == ST_CLEAR);
    assign req_ready = !clearing;
    assign busy      = clearing;
    assign accept    = req_valid && req_ready;
    assign addr_oor  = ({{(32-AW){1'b0}}, req_addr} >= DEPTH_U);
    assign bank_req  = accept && !addr_oor;
    assign req_sel   = 4'(req_addr >> LAW);
    assign req_local = req_addr[LAW-1:0];

    // Clear sweeps one local address per cycle across all banks, then goes idle.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            ST_CLEAR: begin
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == LAW'(WPB - 1)) begin
                    state_d   = ST_IDLE;
                    clr_cnt_d = '0;
                end
            end
            ST_IDLE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Shared bank port: clear writes zeros everywhere, otherwise the request drives it.
    always_comb begin
        bank_we   = req_write;
        bank_addr = req_local;
        bank_din  = req_data;
        if (clearing) begin
            bank_we   = 1'b1;
            bank_addr = clr_cnt_q;
            bank_din  = '0;
        end
    end

    genvar gi;
    for (gi = 0; gi < BLOCKS; gi++) begin : g_bank
        assign bank_ce[gi] = clearing || (bank_req && (req_sel == 4'(gi)));

        bram_bank #(
            .WIDTH (WIDTH),
            .DEPTH (WPB)
        ) u_bank (
            .clk  (clk),
            .ce   (bank_ce[gi]),
            .we   (bank_we),
            .addr (bank_addr),
            .din  (bank_din),
            .dout (bank_dout[gi])
        );
    end

    // Bank select and error travel with the read so the mux lines up with bank data.
    always_comb begin
        rd_vld1_d = accept && !req_write;
        rd_err1_d = addr_oor;
        rd_sel1_d = req_sel;
    end

    // Pick the returning bank's word; an out-of-range read returns zero.
    always_comb begin
        rd_mux = '0;
        if (!rd_err1_q) begin
            for (int i = 0; i < BLOCKS; i++) begin
                if (rd_sel1_q == 4'(i)) begin
                    rd_mux = bank_dout[i];
                end
            end
        end
        out_data_d = rd_vld1_q ? rd_mux : out_data_q;
    end

    // Controller and first pipeline stage; reset drops in-flight reads.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= RESET_STATE;
            clr_cnt_q  <= '0;
            rd_vld1_q  <= 1'b0;
            rd_err1_q  <= 1'b0;
            rd_sel1_q  <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            rd_vld1_q  <= rd_vld1_d;
            rd_err1_q  <= rd_err1_d;
            rd_sel1_q  <= rd_sel1_d;
            out_data_q <= out_data_d;
        end
    end

    if (OUTREG != 0) begin : g_outreg
        logic rd_vld2_q, rd_vld2_d, rd_err2_q, rd_err2_d;

        // Second stage mirrors the first one cycle later.
        always_comb begin
            rd_vld2_d = rd_vld1_q;
            rd_err2_d = rd_err1_q;
        end

        // Output register stage for valid and error.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                rd_vld2_q <= 1'b0;
                rd_err2_q <= 1'b0;
            end else begin
                rd_vld2_q <= rd_vld2_d;
                rd_err2_q <= rd_err2_d;
            end
        end

        assign rsp_valid = rd_vld2_q;
        assign rsp_err   = rd_vld2_q && rd_err2_q;
        assign rsp_data  = out_data_q;
    end else begin : g_direct
        // Data comes straight from the bank mux; out_data_q holds it between responses.
        assign rsp_valid = rd_vld1_q;
        assign rsp_err   = rd_vld1_q && rd_err1_q;
        assign rsp_data  = rd_vld1_q ? rd_mux : out_data_q;
    end

endmodule

// File: tb/tb_bram_array_singleport.sv
// Bench for bram_array_singleport: instance A (WIDTH=8, BLOCKS=4, OUTREG=0) and
// instance B (WIDTH=16, BLOCKS=3, OUTREG=1). Reads push expected responses onto a
// per-instance scoreboard queue; a negedge monitor pops and compares them.
module tb_bram_array_singleport;

    localparam int DEPTH_A = 8192;
    localparam int DEPTH_B = 3072;
    localparam int WPB_A   = 2048;
    localparam int WPB_B   = 1024;

    typedef struct {
        int          due;
        logic        err;
        logic [15:0] data;
        int          addr;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst_a, rv_a, rw_a, rdy_a, vld_a, err_a, busy_a;
    logic [12:0] ra_a;
    logic [7:0]  rd_a, dat_a;
    logic        rst_b, rv_b, rw_b, rdy_b, vld_b, err_b, busy_b;
    logic [11:0] ra_b;
    logic [15:0] rd_b, dat_b;

    bram_array_singleport #(.WIDTH(8), .BLOCKS(4), .OUTREG(0), .CLEAR(1)) dut_a (
        .clk(clk), .reset(rst_a), .req_valid(rv_a), .req_ready(rdy_a), .req_write(rw_a),
        .req_addr(ra_a), .req_data(rd_a), .rsp_valid(vld_a), .rsp_data(dat_a),
        .rsp_err(err_a), .busy(busy_a)
    );

    bram_array_singleport #(.WIDTH(16), .BLOCKS(3), .OUTREG(1), .CLEAR(1)) dut_b (
        .clk(clk), .reset(rst_b), .req_valid(rv_b), .req_ready(rdy_b), .req_write(rw_b),
        .req_addr(ra_b), .req_data(rd_b), .rsp_valid(vld_b), .rsp_data(dat_b),
        .rsp_err(err_b), .busy(busy_b)
    );

    exp_t        sbq [2][$];
    logic [15:0] model [2][8192];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          pulses [2] = '{0, 0};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    task automatic mon(input int d, input logic v, input logic e, input logic [15:0] dt);
        exp_t x;
        if (v) begin
            pulses[d]++;
            if (sbq[d].size() == 0) begin
                check_eq($sformatf("dut%0d unexpected rsp_valid", d), 32'(v), 32'd0);
            end else begin
                x = sbq[d].pop_front();
                $display("dut%0d rd  addr %0d data 0x%0h err %0b cycle %0d", d, x.addr, dt, e, cyc);
                check_eq($sformatf("dut%0d rsp cycle addr %0d", d, x.addr), 32'(cyc), 32'(x.due));
                check_eq($sformatf("dut%0d rsp data addr %0d", d, x.addr), 32'(dt), 32'(x.data));
                check_eq($sformatf("dut%0d rsp err addr %0d", d, x.addr), 32'(e), 32'(x.err));
            end
        end else if (sbq[d].size() != 0 && sbq[d][0].due <= cyc) begin
            x = sbq[d].pop_front();
            check_eq($sformatf("dut%0d missing rsp addr %0d", d, x.addr), 32'(v), 32'd1);
        end
    endtask

    always @(negedge clk) begin
        mon(0, vld_a, err_a, {8'h00, dat_a});
        mon(1, vld_b, err_b, dat_b);
    end

    // Called at a negedge: present one request, record the expectation, move to next negedge.
    task automatic drive(input int d, input bit wr, input int addr, input int data);
        exp_t        x;
        int          depth = (d == 0) ? DEPTH_A : DEPTH_B;
        int          lat   = (d == 0) ? 1 : 2;
        logic [15:0] m     = (d == 0) ? 16'h00ff : 16'hffff;
        if (d == 0) begin
            rv_a = 1'b1; rw_a = wr; ra_a = 13'(addr); rd_a = 8'(data);
        end else begin
            rv_b = 1'b1; rw_b = wr; ra_b = 12'(addr); rd_b = 16'(data);
        end
        if (wr) begin
            if (addr < depth) model[d][addr] = 16'(data) & m;
            $display("dut%0d wr  addr %0d data 0x%0h cycle %0d", d, addr, 16'(data) & m, cyc);
        end else begin
            x.due  = cyc + lat;
            x.err  = (addr >= depth);
            x.data = x.err ? 16'h0000 : model[d][addr];
            x.addr = addr;
            sbq[d].push_back(x);
        end
        @(negedge clk);
    endtask

    task automatic idle();
        rv_a = 1'b0;
        rv_b = 1'b0;
    endtask

    function automatic logic busy_of(input int d);
        return (d == 0) ? busy_a : busy_b;
    endfunction

    // Called at the negedge where reset was released: count busy cycles, then reset the model.
    task automatic wait_clear(input int d, input int wpb, input string tag);
        int n = 0;
        while (busy_of(d) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, 32'(n), 32'(wpb));
        for (int i = 0; i < 8192; i++) model[d][i] = 16'h0000;
    endtask

    int ad [6];
    int p0, p1, n;

    initial begin
        rst_a = 1'b1; rv_a = 1'b0; rw_a = 1'b0; ra_a = '0; rd_a = '0;
        rst_b = 1'b1; rv_b = 1'b0; rw_b = 1'b0; ra_b = '0; rd_b = '0;
        repeat (3) @(negedge clk);
        check_eq("A reset rsp_valid", 32'(vld_a), 32'd0);
        check_eq("A reset rsp_data", 32'(dat_a), 32'd0);
        check_eq("A reset busy", 32'(busy_a), 32'd1);
        check_eq("A reset req_ready", 32'(rdy_a), 32'd0);
        check_eq("B reset rsp_data", 32'(dat_b), 32'd0);
        check_eq("B reset busy", 32'(busy_b), 32'd1);

        // ---------------- instance A ----------------
        rst_a = 1'b0;
        wait_clear(0, WPB_A, "A clear length");
        check_eq("A ready after clear", 32'(rdy_a), 32'd1);
        drive(0, 0, 0, 0);
        drive(0, 0, 2047, 0);
        drive(0, 0, 8191, 0);
        drive(0, 1, 5000, 'hA5);
        drive(0, 0, 5000, 0);
        drive(0, 1, 2047, 'h11);
        drive(0, 1, 2048, 'h22);
        drive(0, 1, 6143, 'h33);
        drive(0, 1, 6144, 'h44);
        drive(0, 0, 2047, 0);
        drive(0, 0, 2048, 0);
        drive(0, 0, 6143, 0);
        drive(0, 0, 6144, 0);
        for (int i = 0; i < 6; i++) begin
            ad[i] = int'($urandom_range(0, DEPTH_A - 1));
            drive(0, 1, ad[i], int'($urandom_range(1, 255)));
        end
        for (int i = 0; i < 6; i++) drive(0, 0, ad[i], 0);
        drive(0, 0, 5000, 0);
        idle();
        repeat (4) @(negedge clk);
        check_eq("A rsp_data hold", 32'(dat_a), 32'(model[0][5000]));
        check_eq("A rsp_valid idle", 32'(vld_a), 32'd0);

        // Reset, then reset again 700 cycles into the clear.
        p0 = pulses[0];
        rst_a = 1'b1;
        @(negedge clk);
        check_eq("A reset rsp_data zero", 32'(dat_a), 32'd0);
        rst_a = 1'b0;
        repeat (700) @(negedge clk);
        rst_a = 1'b1;
        @(negedge clk);
        check_eq("A busy during reset", 32'(busy_a), 32'd1);
        rst_a = 1'b0;
        wait_clear(0, WPB_A, "A clear after mid-clear reset");
        check_eq("A no rsp across reset", 32'(pulses[0] - p0), 32'd0);
        drive(0, 0, 5000, 0);
        drive(0, 0, 2048, 0);
        idle();

        // ---------------- instance B ----------------
        rst_b = 1'b0;
        wait_clear(1, WPB_B, "B clear length");
        drive(1, 1, 1023, 'h1111);
        drive(1, 1, 1024, 'h2222);
        drive(1, 1, 1025, 'h3333);
        drive(1, 0, 1023, 0);
        drive(1, 0, 1024, 0);
        drive(1, 0, 1025, 0);
        drive(1, 0, 3072, 0);
        drive(1, 1, 3072, 'hBEEF);
        drive(1, 0, 0, 0);
        drive(1, 0, 1024, 0);
        drive(1, 0, 2048, 0);
        drive(1, 0, 3071, 0);
        drive(1, 0, 3072, 0);
        drive(1, 0, 4095, 0);
        drive(1, 1, 2000, 'hA5A5);
        drive(1, 0, 2000, 0);
        idle();
        repeat (4) @(negedge clk);
        check_eq("B rsp_data hold", 32'(dat_b), 32'h0000A5A5);

        // Reset while a read is in flight in the output pipeline.
        p1 = pulses[1];
        drive(1, 0, 2000, 0);
        idle();
        rst_b = 1'b1;
        sbq[1].delete();
        #1;
        check_eq("B reset mid-read rsp_valid", 32'(vld_b), 32'd0);
        check_eq("B reset mid-read rsp_data", 32'(dat_b), 32'd0);
        check_eq("B reset mid-read rsp_err", 32'(err_b), 32'd0);
        repeat (3) @(negedge clk);
        rst_b = 1'b0;
        wait_clear(1, WPB_B, "B clear after reset");
        check_eq("B no rsp for dropped read", 32'(pulses[1] - p1), 32'd0);
        drive(1, 0, 2000, 0);
        idle();

        n = 0;
        while ((sbq[0].size() != 0 || sbq[1].size() != 0) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("scoreboard drained", 32'(sbq[0].size() + sbq[1].size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
